// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core pipeline, the arbiter and the memory macro.
// The slave modport is the arbiter's view; master is the surrounding core/memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and load/store. Data normally wins; after MAX_STREAK consecutive data grants
// with fetch waiting, fetch is forced through. One transaction in flight.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic               clk,
    input  logic               rstn,
    mem_port_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]        stat_total,
    output logic [31:0]        stat_conflict,
    output logic [31:0]        stat_if_wait
`endif
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STR_W = $clog2(MAX_STREAK + 1);
    localparam logic [STR_W-1:0] STR_MAX  = STR_W'(MAX_STREAK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              own_d_q;    // 1 = data stage owns the transaction
    logic              own_we_q;   // owner transaction is a store
    logic [STR_W-1:0]  streak_q;
    logic [STR_W-1:0]  streak_d;

    logic grant;
    logic pick_d;
    logic done;

    // Winner selection and memory strobe; grants are suppressed while in reset
    // because the state register already reads IDLE then.
    always_comb begin
        pick_d        = bus.d_req && !(bus.if_req && (streak_q == STR_MAX));
        grant         = rstn && (state_q == IDLE) && (bus.if_req || bus.d_req);
        bus.d_gnt     = grant && pick_d;
        bus.if_gnt    = grant && !pick_d;
        bus.mem_en    = grant;
        bus.mem_we    = bus.d_gnt && bus.d_we;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        if (bus.d_gnt) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_wstrb = bus.d_wstrb;
        end else if (bus.if_gnt) begin
            bus.mem_addr  = bus.if_addr;
        end
    end

    // Streak of data grants taken while fetch was kept waiting.
    always_comb begin
        streak_d = '0;
        if (pick_d && bus.if_req)
            streak_d = (streak_q == STR_MAX) ? streak_q : streak_q + 1'b1;
    end

    // Response return to the owner in the DONE cycle; stores return zero data.
    always_comb begin
        done          = (state_q == DONE);
        bus.if_rvalid = done && !own_d_q;
        bus.d_rvalid  = done && own_d_q;
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
        bus.d_rdata   = (bus.d_rvalid && !own_we_q) ? bus.mem_rdata : '0;
    end

    // Transaction FSM: IDLE grants, BUSY waits out the memory latency, DONE returns.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            own_d_q  <= 1'b0;
            own_we_q <= 1'b0;
            streak_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        own_d_q  <= pick_d;
                        own_we_q <= pick_d && bus.d_we;
                        streak_q <= streak_d;
                        cnt_q    <= CNT_W'(1);
                        state_q  <= (MEM_LAT == 1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == CNT_LAST) state_q <= DONE;
                    else                   cnt_q   <= cnt_q + 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] stat_total_q, stat_conflict_q, stat_if_wait_q;

    // Free-running wrapping event counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_total_q    <= '0;
            stat_conflict_q <= '0;
            stat_if_wait_q  <= '0;
        end else begin
            if (grant)                             stat_total_q    <= stat_total_q + 32'd1;
            if (grant && bus.if_req && bus.d_req)  stat_conflict_q <= stat_conflict_q + 32'd1;
            if (bus.if_req && !bus.if_gnt)         stat_if_wait_q  <= stat_if_wait_q + 32'd1;
        end
    end

    assign stat_total    = stat_total_q;
    assign stat_conflict = stat_conflict_q;
    assign stat_if_wait  = stat_if_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a (MEM_LAT=2, MAX_STREAK=4)
// and instance b (MEM_LAT=1). Inputs change just after the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

`ifdef ARB_STATS_EN
    logic [31:0] a_tot, a_con, a_wait, b_tot, b_con, b_wait;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_STREAK(4)) dut_a (
        .clk(clk), .rstn(rstn), .bus(ifa)
`ifdef ARB_STATS_EN
        , .stat_total(a_tot), .stat_conflict(a_con), .stat_if_wait(a_wait)
`endif
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_STREAK(4)) dut_b (
        .clk(clk), .rstn(rstn), .bus(ifb)
`ifdef ARB_STATS_EN
        , .stat_total(b_tot), .stat_conflict(b_con), .stat_if_wait(b_wait)
`endif
    );

    // Memory model: reads latch the address; data is a fixed function of it.
    logic [31:0] rda = 32'h0, rdb = 32'h0;
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h40) ? 32'h00A00093 : (a ^ 32'h5A5A0000);
    endfunction
    always @(posedge clk) begin
        if (ifa.mem_en && !ifa.mem_we) rda <= ifa.mem_addr;
        if (ifb.mem_en && !ifb.mem_we) rdb <= ifb.mem_addr;
    end
    assign ifa.mem_rdata = memfn(rda);
    assign ifb.mem_rdata = memfn(rdb);

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        cyc();
        rstn = 1'b0; ifa.if_req = 1'b1; ifa.d_req = 1'b1; ifb.if_req = 1'b1;
        #1;
        total++; if (ifa.if_gnt !== 1'b0 || ifa.d_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got if=%b d=%b exp 0 0", ifa.if_gnt, ifa.d_gnt); end
        total++; if (ifa.mem_en !== 1'b0 || ifb.mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got a=%b b=%b exp 0 0", ifa.mem_en, ifb.mem_en); end
        total++; if (ifa.if_rvalid !== 1'b0 || ifa.d_rvalid !== 1'b0 || ifa.d_rdata !== 32'h0) begin bad++; $display("FAIL reset_rvalid got if=%b d=%b rdata=%h exp 0 0 0", ifa.if_rvalid, ifa.d_rvalid, ifa.d_rdata); end
`ifdef ARB_STATS_EN
        total++; if (a_tot !== 32'h0 || a_con !== 32'h0 || a_wait !== 32'h0) begin bad++; $display("FAIL reset_stats got %0d %0d %0d exp 0 0 0", a_tot, a_con, a_wait); end
`endif
        cyc();
        ifa.if_req = 1'b0; ifa.d_req = 1'b0; ifb.if_req = 1'b0; rstn = 1'b1;
        drain(2);
    endtask

    task automatic test_fetch();
        cyc(); ifa.if_req = 1'b1; ifa.if_addr = 32'h40; #1;
        total++; if (ifa.if_gnt !== 1'b1 || ifa.d_gnt !== 1'b0) begin bad++; $display("FAIL fetch_gnt got if=%b d=%b exp 1 0", ifa.if_gnt, ifa.d_gnt); end
        total++; if (ifa.mem_en !== 1'b1 || ifa.mem_addr !== 32'h40 || ifa.mem_we !== 1'b0 || ifa.mem_wstrb !== 4'h0) begin bad++; $display("FAIL fetch_mem got en=%b addr=%h we=%b strb=%h exp 1 40 0 0", ifa.mem_en, ifa.mem_addr, ifa.mem_we, ifa.mem_wstrb); end
        cyc(); ifa.if_addr = 32'h44; #1;
        total++; if (ifa.if_gnt !== 1'b0 || ifa.mem_en !== 1'b0 || ifa.if_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_busy got gnt=%b en=%b rv=%b exp 0 0 0", ifa.if_gnt, ifa.mem_en, ifa.if_rvalid); end
        cyc(); #1;
        total++; if (ifa.if_gnt !== 1'b0 || ifa.if_rvalid !== 1'b1 || ifa.d_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_done got gnt=%b rv=%b drv=%b exp 0 1 0", ifa.if_gnt, ifa.if_rvalid, ifa.d_rvalid); end
        total++; if (ifa.if_rdata !== 32'h00A00093) begin bad++; $display("FAIL fetch_rdata got %h exp 00a00093", ifa.if_rdata); end
        cyc(); #1;
        total++; if (ifa.if_gnt !== 1'b1 || ifa.mem_addr !== 32'h44) begin bad++; $display("FAIL fetch_next_gnt got gnt=%b addr=%h exp 1 44", ifa.if_gnt, ifa.mem_addr); end
        cyc(); ifa.if_req = 1'b0;
        drain(4);
    endtask

    task automatic test_simultaneous();
        cyc(); rstn = 1'b0;
        cyc(); rstn = 1'b1;
        cyc();
        ifa.if_req = 1'b1; ifa.if_addr = 32'h48;
        ifa.d_req = 1'b1; ifa.d_we = 1'b0; ifa.d_addr = 32'h200; ifa.d_wstrb = 4'hF; #1;
        total++; if (ifa.d_gnt !== 1'b1 || ifa.if_gnt !== 1'b0) begin bad++; $display("FAIL simul_gnt got d=%b if=%b exp 1 0", ifa.d_gnt, ifa.if_gnt); end
        cyc(); ifa.d_req = 1'b0; #1;
        total++; if (ifa.if_gnt !== 1'b0) begin bad++; $display("FAIL simul_wait1 got %b exp 0", ifa.if_gnt); end
        cyc(); #1;
        total++; if (ifa.if_gnt !== 1'b0 || ifa.d_rvalid !== 1'b1 || ifa.if_rvalid !== 1'b0) begin bad++; $display("FAIL simul_done got gnt=%b drv=%b irv=%b exp 0 1 0", ifa.if_gnt, ifa.d_rvalid, ifa.if_rvalid); end
        total++; if (ifa.d_rdata !== 32'h5A5A0200 || ifa.if_rdata !== 32'h0) begin bad++; $display("FAIL simul_rdata got d=%h if=%h exp 5a5a0200 0", ifa.d_rdata, ifa.if_rdata); end
        cyc(); #1;
        total++; if (ifa.if_gnt !== 1'b1 || ifa.mem_addr !== 32'h48) begin bad++; $display("FAIL simul_if_gnt got gnt=%b addr=%h exp 1 48", ifa.if_gnt, ifa.mem_addr); end
        cyc(); ifa.if_req = 1'b0; #1;
`ifdef ARB_STATS_EN
        total++; if (a_tot !== 32'd2 || a_con !== 32'd1 || a_wait !== 32'd3) begin bad++; $display("FAIL simul_stats got tot=%0d con=%0d wait=%0d exp 2 1 3", a_tot, a_con, a_wait); end
`endif
        drain(4);
    endtask

    task automatic test_store();
        cyc();
        ifa.d_req = 1'b1; ifa.d_we = 1'b1; ifa.d_addr = 32'h100; ifa.d_wdata = 32'hDEADBEEF; ifa.d_wstrb = 4'h3; #1;
        total++; if (ifa.d_gnt !== 1'b1 || ifa.mem_en !== 1'b1 || ifa.mem_we !== 1'b1) begin bad++; $display("FAIL store_gnt got gnt=%b en=%b we=%b exp 1 1 1", ifa.d_gnt, ifa.mem_en, ifa.mem_we); end
        total++; if (ifa.mem_addr !== 32'h100 || ifa.mem_wdata !== 32'hDEADBEEF || ifa.mem_wstrb !== 4'h3) begin bad++; $display("FAIL store_bus got addr=%h wdata=%h strb=%h exp 100 deadbeef 3", ifa.mem_addr, ifa.mem_wdata, ifa.mem_wstrb); end
        cyc(); ifa.d_req = 1'b0; ifa.d_we = 1'b0;
        cyc(); #1;
        total++; if (ifa.d_rvalid !== 1'b1 || ifa.d_rdata !== 32'h0) begin bad++; $display("FAIL store_done got rv=%b rdata=%h exp 1 0", ifa.d_rvalid, ifa.d_rdata); end
        drain(3);
    endtask

    task automatic test_streak();
        logic [9:0] expd = 10'b1111011110;
        int n = 0;
        ifa.d_we = 1'b0; ifa.d_addr = 32'h300; ifa.if_addr = 32'h80;
        for (int i = 0; i < 60 && n < 10; i++) begin
            cyc(); ifa.if_req = 1'b1; ifa.d_req = 1'b1; #1;
            if (ifa.d_gnt || ifa.if_gnt) begin
                total++;
                if (ifa.d_gnt !== expd[9-n] || ifa.if_gnt !== !expd[9-n]) begin
                    bad++; $display("FAIL streak_order idx=%0d got d=%b f=%b exp d=%b", n, ifa.d_gnt, ifa.if_gnt, expd[9-n]);
                end
                n++;
            end
        end
        total++; if (n != 10) begin bad++; $display("FAIL streak_timeout got %0d grants exp 10", n); end
        cyc(); ifa.if_req = 1'b0; ifa.d_req = 1'b0;
        drain(4);
    endtask

    task automatic test_busy_reset();
        cyc(); ifa.if_req = 1'b1; ifa.if_addr = 32'h40; #1;
        total++; if (ifa.if_gnt !== 1'b1) begin bad++; $display("FAIL rst_pre_gnt got %b exp 1", ifa.if_gnt); end
        cyc(); ifa.if_req = 1'b0; rstn = 1'b0; #1;
        total++; if (ifa.if_rvalid !== 1'b0 || ifa.d_rvalid !== 1'b0) begin bad++; $display("FAIL rst_busy_rv got if=%b d=%b exp 0 0", ifa.if_rvalid, ifa.d_rvalid); end
        cyc(); #1;
        total++; if (ifa.if_rvalid !== 1'b0) begin bad++; $display("FAIL rst_done_slot_rv got %b exp 0", ifa.if_rvalid); end
        cyc(); rstn = 1'b1; #1;
        total++; if (ifa.if_rvalid !== 1'b0 || ifa.mem_en !== 1'b0) begin bad++; $display("FAIL rst_release got rv=%b en=%b exp 0 0", ifa.if_rvalid, ifa.mem_en); end
`ifdef ARB_STATS_EN
        total++; if (a_tot !== 32'h0 || a_con !== 32'h0 || a_wait !== 32'h0) begin bad++; $display("FAIL rst_stats got %0d %0d %0d exp 0 0 0", a_tot, a_con, a_wait); end
`endif
        cyc(); ifa.d_req = 1'b1; ifa.d_we = 1'b0; ifa.d_addr = 32'h300; #1;
        total++; if (ifa.d_gnt !== 1'b1 || ifa.mem_addr !== 32'h300) begin bad++; $display("FAIL rst_fresh_gnt got gnt=%b addr=%h exp 1 300", ifa.d_gnt, ifa.mem_addr); end
        cyc(); ifa.d_req = 1'b0;
        drain(4);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            cyc(); ifb.if_req = 1'b1; ifb.if_addr = 32'h40 + 32'(4 * (i / 2)); #1;
            total++;
            if (ifb.if_gnt !== ((i % 2) == 0) || ifb.if_rvalid !== ((i % 2) == 1)) begin
                bad++; $display("FAIL b2b_cycle%0d got gnt=%b rv=%b exp %b %b", i, ifb.if_gnt, ifb.if_rvalid, (i % 2) == 0, (i % 2) == 1);
            end
            if (i == 1) begin
                total++; if (ifb.if_rdata !== 32'h00A00093) begin bad++; $display("FAIL b2b_rdata0 got %h exp 00a00093", ifb.if_rdata); end
            end
            if (i == 3) begin
                total++; if (ifb.if_rdata !== 32'h5A5A0044) begin bad++; $display("FAIL b2b_rdata1 got %h exp 5a5a0044", ifb.if_rdata); end
            end
        end
        cyc(); ifb.if_req = 1'b0;
        drain(3);
    endtask

    initial begin
        ifa.if_req = 1'b0; ifa.if_addr = '0; ifa.d_req = 1'b0; ifa.d_we = 1'b0;
        ifa.d_addr = '0; ifa.d_wdata = '0; ifa.d_wstrb = '0;
        ifb.if_req = 1'b0; ifb.if_addr = '0; ifb.d_req = 1'b0; ifb.d_we = 1'b0;
        ifb.d_addr = '0; ifb.d_wdata = '0; ifb.d_wstrb = '0;
        drain(2);
        test_reset();
        test_fetch();
        test_simultaneous();
        test_store();
        test_streak();
        test_busy_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single-port unified memory between the instruction-fetch stage and the load/store stage. Accepts one request per requester, issues at most one memory transaction at a time, and returns read data or write completion to the owner. Data accesses normally win so the pipeline drains. A streak limit guarantees fetch progress. Sits between the core pipeline and the memory macro; fetch/MEM stages stall on `*_req && !*_gnt` and until `*_rvalid`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (multiple of 8)
- `MEM_LAT`, 2, cycles from `mem_en` to valid `mem_rdata` (≥1)
- `MAX_STREAK`, 4, max consecutive data grants while fetch waits (≥1)

- `clk`  in  1  clock, rising edge
- `rstn`  in  1  asynchronous active-low reset
- `if_req`  in  1  fetch request, held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req`
- `if_gnt`  out  1  fetch accepted this cycle
- `if_rvalid`  out  1  fetch data valid pulse
- `if_rdata`  out  DATA_W  fetch data
- `d_req`  in  1  data request, held until `d_gnt`
- `d_we`  in  1  1 = write
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_wstrb`  in  DATA_W/8  byte enables
- `d_gnt`  out  1  data accepted this cycle
- `d_rvalid`  out  1  load data valid / store complete pulse
- `d_rdata`  out  DATA_W  load data (0 for stores)
- `mem_en`, `mem_we`  out  1  memory strobe / write enable
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W; `mem_wstrb`  out  DATA_W/8
- `mem_rdata`  in  DATA_W  memory read data
- `stat_total`, `stat_conflict`, `stat_if_wait`  out  32 each  (only with `ARB_STATS_EN`)

## Operation
- FSM: `IDLE`, `BUSY`, `DONE`. Reset → `IDLE`, all outputs 0, streak 0, owner = fetch.
- `IDLE`: if any request, select winner combinationally, assert its `*_gnt` and `mem_en` with its address/we/wdata/wstrb (fetch: `mem_we`=0, wstrb=0), record owner, go `BUSY` (or `DONE` if `MEM_LAT`=1). No request → stay, `mem_en`=0.
- Priority: data wins unless `if_req && streak == MAX_STREAK`, then fetch wins.
- Streak: data grant with `if_req` high → streak+1 (saturates at MAX_STREAK); data grant with `if_req` low or any fetch grant → 0.
- `BUSY`: latency counter; after `MEM_LAT-1` cycles → `DONE`. Requests ignored, no grants.
- `DONE`: pulse owner's `*_rvalid` one cycle; `*_rdata` = `mem_rdata` (0 for stores); non-owner rvalid/rdata = 0. Next cycle → `IDLE`.
- One transaction outstanding; no grant in `BUSY`/`DONE`.
- `rstn` low at any point: transaction dropped, no rvalid, FSM `IDLE`, streak and stats 0 immediately.

## Timing
- Grant in cycle T (same cycle request seen in `IDLE`); `mem_en` high only in T.
- `*_rvalid` in T+MEM_LAT; earliest next grant T+MEM_LAT+1.
- Throughput: one access per MEM_LAT+1 cycles.
- `*_gnt`, `mem_*` combinational from state and inputs; `*_rvalid`/`*_rdata` from state and `mem_rdata`.
- Both requests in same `IDLE` cycle: exactly one gnt; loser keeps request, served after next `DONE` unless re-lost per priority.

## Configuration
- `ARB_STATS_EN` defined: three 32-bit wrapping counters, reset 0. `stat_total` +1 per grant. `stat_conflict` +1 per grant cycle with both requests high. `stat_if_wait` +1 per cycle `if_req` high without `if_gnt`.
- Undefined: counters and `stat_*` ports absent; arbitration unchanged.

## Test plan
- Fetch only, `MEM_LAT`=2, addr 0x40, memory returns 0x00A00093 → `if_gnt` at T, `if_rvalid` at T+2 with 0x00A00093, next grant no earlier than T+3.
- Simultaneous requests at T → `d_gnt` at T, `if_gnt` at T+3. With stats: `stat_conflict`=1, `stat_if_wait`=3.
- Store addr 0x100 wdata 0xDEADBEEF wstrb 0x3 → `mem_we`=1, `mem_wstrb`=0x3 in grant cycle; `d_rvalid` at T+2, `d_rdata`=0.
- `d_req` and `if_req` held high continuously, `MAX_STREAK`=4 → grant order D,D,D,D,F,D,D,D,D,F.
- `rstn` low in `BUSY` → no `*_rvalid`; after release, `IDLE` grants fresh request; stats read 0.
- `MEM_LAT`=1 back-to-back fetches → grants every 2 cycles, rvalid cycle after each grant.
